// File: rtl/adc_serial_rx.sv
// -----------------------------------------------------------------------------
// adc_serial_rx
//
// Runs the conversion + serial readout cycle of a dual-channel serial ADC and
// splits each ADC_DATA_WIDTH-bit frame (MSB first, channel 1 first) into two
// CHAN_WIDTH-bit samples for the downstream integrator/range stage.
//
// Optional feature (compile-time macro): ADC_RX_OVERRUN_EN
//   defined   -> overrun is a sticky flag set one cycle after a trigger that
//                arrives while busy; cleared only by rst.
//   undefined -> overrun is tied to 0 and no detection logic exists.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   trigger       start one conversion + readout (honoured only in IDLE)
//   adc_sdo       serial data from ADC, sampled on adc_sck rising edges
//   adc_cnv       conversion start to ADC, high for CONV_CYCLES cycles
//   adc_sck       serial clock to ADC, low outside READ
//   sample_1      channel 1 = frame bits [ADC_DATA_WIDTH-1:CHAN_WIDTH]
//   sample_2      channel 2 = frame bits [CHAN_WIDTH-1:0]
//   sample_valid  one-cycle strobe, samples are new in the same cycle
//   busy          high whenever the FSM is not IDLE
//   overrun       sticky retrigger-while-busy flag (see macro above)
// -----------------------------------------------------------------------------
module adc_serial_rx #(
  parameter int ADC_DATA_WIDTH = 36,
  parameter int CHAN_WIDTH     = 18,
  parameter int CLK_DIV        = 2,
  parameter int CONV_CYCLES    = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  adc_sdo,
  output logic                  adc_cnv,
  output logic                  adc_sck,
  output logic [CHAN_WIDTH-1:0] sample_1,
  output logic [CHAN_WIDTH-1:0] sample_2,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  // Counter widths; a width of 0 is not legal, so single-value counters keep
  // one bit that simply stays at zero.
  localparam int BIT_W  = $clog2(ADC_DATA_WIDTH + 1);
  localparam int DIV_W  = (CLK_DIV > 1)     ? $clog2(CLK_DIV)     : 1;
  localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CONV_W-1:0] CONV_LAST  = CONV_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0]  FRAME_BITS = BIT_W'(ADC_DATA_WIDTH);

  if (ADC_DATA_WIDTH != 2 * CHAN_WIDTH) begin : g_bad_width
    $error("adc_serial_rx: ADC_DATA_WIDTH must equal 2*CHAN_WIDTH");
  end
  if (CLK_DIV < 1 || CONV_CYCLES < 1) begin : g_bad_timing
    $error("adc_serial_rx: CLK_DIV and CONV_CYCLES must be >= 1");
  end

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    CONV = 4'b0010,
    READ = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t                    state, state_next;
  logic [CONV_W-1:0]         conv_cnt;
  logic [DIV_W-1:0]          div_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [ADC_DATA_WIDTH-1:0] shift_reg;
  logic                      sck_q;

  logic conv_last;
  logic div_last;
  logic frame_done;
  logic read_end;

  assign conv_last  = (conv_cnt == CONV_LAST);
  assign div_last   = (div_cnt == DIV_LAST);
  assign frame_done = (bit_cnt == FRAME_BITS);
  // Last high phase of the frame is finishing: sck falls and READ ends.
  assign read_end   = div_last && sck_q && frame_done;

  assign adc_sck = sck_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    adc_cnv      = 1'b0;
    sample_valid = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (trigger) state_next = CONV;
      end
      CONV: begin
        adc_cnv = 1'b1;
        if (conv_last) state_next = READ;
      end
      READ: begin
        if (read_end) state_next = DONE;
      end
      DONE: begin
        sample_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: conversion timer, sck divider, bit counter, shifter, samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_cnt  <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      sck_q     <= 1'b0;
      sample_1  <= '0;
      sample_2  <= '0;
    end else begin
      case (state)
        CONV: begin
          conv_cnt <= conv_last ? '0 : conv_cnt + 1'b1;
          // Divider, bit counter and sck start fresh on entry to READ.
          div_cnt  <= '0;
          bit_cnt  <= '0;
          sck_q    <= 1'b0;
        end
        READ: begin
          if (div_last) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
            if (!sck_q) begin
              // Low->high toggle: capture the bit the ADC is presenting.
              shift_reg <= {shift_reg[ADC_DATA_WIDTH-2:0], adc_sdo};
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          // Load on the edge into DONE so samples are new while the strobe is up.
          if (read_end) begin
            sample_1 <= shift_reg[ADC_DATA_WIDTH-1:CHAN_WIDTH];
            sample_2 <= shift_reg[CHAN_WIDTH-1:0];
          end
        end
        default: begin
          conv_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ADC_RX_OVERRUN_EN
  // Sticky: a trigger while busy is dropped, and this records that it was.
  always_ff @(posedge clk) begin
    if (rst)                  overrun <= 1'b0;
    else if (trigger && busy) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_adc_serial_rx
//
// Directed bench for adc_serial_rx. Two instances share clk/rst:
//   dut_a : default parameters (CLK_DIV=2, CONV_CYCLES=40)
//   dut_b : CLK_DIV=1, CONV_CYCLES=1
// Each has a small ADC model that presents the frame MSB first and advances
// to the next bit after each adc_sck rising edge.
// Cycle numbering: trigger is driven high in cycle T (k=0); k counts cycles
// after T, observed at the falling edge of clk.
// -----------------------------------------------------------------------------
module tb_adc_serial_rx;

`ifdef ADC_RX_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        trig_a = 1'b0, sdo_a, cnv_a, sck_a, valid_a, busy_a, ovr_a;
  logic [17:0] s1_a, s2_a;
  logic        trig_b = 1'b0, sdo_b, cnv_b, sck_b, valid_b, busy_b, ovr_b;
  logic [17:0] s1_b, s2_b;

  logic [35:0] frame_a = '0, frame_b = '0;
  logic [35:0] msr_a = '0, msr_b = '0;
  logic        sck_d_a = 1'b0, sck_d_b = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_serial_rx dut_a (
    .clk(clk), .rst(rst), .trigger(trig_a), .adc_sdo(sdo_a),
    .adc_cnv(cnv_a), .adc_sck(sck_a), .sample_1(s1_a), .sample_2(s2_a),
    .sample_valid(valid_a), .busy(busy_a), .overrun(ovr_a)
  );

  adc_serial_rx #(.CLK_DIV(1), .CONV_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .trigger(trig_b), .adc_sdo(sdo_b),
    .adc_cnv(cnv_b), .adc_sck(sck_b), .sample_1(s1_b), .sample_2(s2_b),
    .sample_valid(valid_b), .busy(busy_b), .overrun(ovr_b)
  );

  // ADC models: frame latched during conversion, next bit after each sck rise.
  assign sdo_a = msr_a[35];
  assign sdo_b = msr_b[35];

  always @(posedge clk) begin
    sck_d_a <= sck_a;
    if (cnv_a)                  msr_a <= frame_a;
    else if (sck_a && !sck_d_a) msr_a <= msr_a << 1;
    sck_d_b <= sck_b;
    if (cnv_b)                  msr_b <= frame_b;
    else if (sck_b && !sck_d_b) msr_b <= msr_b << 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int vcnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, cnv_a, sck_a, valid_a, ovr_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy_a, cnv_a, sck_a, valid_a, ovr_a});
    end
    checks++;
    if ({s1_a, s2_a} !== 36'h0) begin
      errors++;
      $display("FAIL reset_samples: got %h expected 000000000", {s1_a, s2_a});
    end
    // Start a frame and reset in the middle of READ.
    frame_a = 36'hA_AAAA_AAAA;
    trig_a  = 1'b1;
    @(negedge clk);
    trig_a  = 1'b0;
    repeat (59) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: got %b expected 1", busy_a);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, cnv_a, sck_a, valid_a} !== 4'b0) begin
      errors++;
      $display("FAIL reset_midread_ctrl: got %b expected 0000", {busy_a, cnv_a, sck_a, valid_a});
    end
    checks++;
    if ({s1_a, s2_a} !== 36'h0) begin
      errors++;
      $display("FAIL reset_midread_samples: got %h expected 000000000", {s1_a, s2_a});
    end
    rst  = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (valid_a === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0) begin
      errors++;
      $display("FAIL reset_no_valid: got %0d strobes expected 0", vcnt);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy_a);
    end
  endtask

  task automatic test_ignored_trigger();
    int vk, vcnt;
    vk = -1; vcnt = 0;
    frame_a = 36'h0_0001_FFFF;
    trig_a  = 1'b1;
    for (int k = 1; k <= 190; k++) begin
      @(negedge clk);
      if (k == 1) trig_a = 1'b0;
      if (k == 50) begin
        checks++;
        if (ovr_a !== 1'b0) begin
          errors++;
          $display("FAIL ign_ovr_before: got %b expected 0", ovr_a);
        end
        trig_a = 1'b1;
      end
      if (k == 51) begin
        trig_a = 1'b0;
        checks++;
        if (ovr_a !== EXP_OVR) begin
          errors++;
          $display("FAIL ign_ovr_after: got %b expected %b", ovr_a, EXP_OVR);
        end
      end
      if (valid_a === 1'b1) begin
        vcnt++;
        if (vk < 0) vk = k;
      end
    end
    checks++;
    if (vk != 185 || vcnt != 1) begin
      errors++;
      $display("FAIL ign_valid: got cycle %0d count %0d expected cycle 185 count 1", vk, vcnt);
    end
    checks++;
    if (s1_a !== 18'h0 || s2_a !== 18'h1FFFF) begin
      errors++;
      $display("FAIL ign_samples: got %h/%h expected 00000/1ffff", s1_a, s2_a);
    end
  endtask

  task automatic test_single_frame();
    int vk, vcnt, rises, cnv_err, sck_err, busy_err;
    logic prev_sck, exp_sck;
    vk = -1; vcnt = 0; rises = 0; cnv_err = 0; sck_err = 0; busy_err = 0;
    prev_sck = 1'b0;
    frame_a  = 36'h9_ABCD_1234;
    trig_a   = 1'b1;
    for (int k = 1; k <= 190; k++) begin
      @(negedge clk);
      if (k == 1) trig_a = 1'b0;
      if (cnv_a !== (k <= 40)) cnv_err++;
      exp_sck = (k >= 41 && k <= 184) && ((((k - 41) / 2) % 2) == 1);
      if (sck_a !== exp_sck) sck_err++;
      if (busy_a !== (k <= 185)) busy_err++;
      if (sck_a === 1'b1 && prev_sck === 1'b0) rises++;
      prev_sck = sck_a;
      if (valid_a === 1'b1) begin
        vcnt++;
        if (vk < 0) vk = k;
      end
    end
    checks++;
    if (cnv_err != 0) begin
      errors++;
      $display("FAIL single_cnv: got %0d bad cycles expected 0", cnv_err);
    end
    checks++;
    if (sck_err != 0 || rises != 36) begin
      errors++;
      $display("FAIL single_sck: got %0d bad cycles %0d rises expected 0 bad 36 rises", sck_err, rises);
    end
    checks++;
    if (busy_err != 0) begin
      errors++;
      $display("FAIL single_busy: got %0d bad cycles expected 0", busy_err);
    end
    checks++;
    if (vk != 185 || vcnt != 1) begin
      errors++;
      $display("FAIL single_valid: got cycle %0d count %0d expected cycle 185 count 1", vk, vcnt);
    end
    checks++;
    if (s1_a !== 18'h26AF3 || s2_a !== 18'h11234) begin
      errors++;
      $display("FAIL single_samples: got %h/%h expected 26af3/11234", s1_a, s2_a);
    end
  endtask

  task automatic test_alternating();
    int vk;
    vk = -1;
    frame_a = 36'hA_AAAA_AAAA;
    trig_a  = 1'b1;
    for (int k = 1; k <= 190; k++) begin
      @(negedge clk);
      if (k == 1) trig_a = 1'b0;
      if (valid_a === 1'b1 && vk < 0) vk = k;
    end
    checks++;
    if (vk != 185) begin
      errors++;
      $display("FAIL alt_valid: got cycle %0d expected 185", vk);
    end
    checks++;
    if (s1_a !== 18'h2AAAA || s2_a !== 18'h2AAAA) begin
      errors++;
      $display("FAIL alt_samples: got %h/%h expected 2aaaa/2aaaa", s1_a, s2_a);
    end
  endtask

  task automatic test_back_to_back();
    int vks[$];
    int rks[$];
    logic prev_cnv;
    prev_cnv = 1'b0;
    frame_a  = 36'h9_ABCD_1234;
    trig_a   = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 300) trig_a = 1'b0;
      if (cnv_a === 1'b1 && prev_cnv === 1'b0) rks.push_back(k);
      prev_cnv = cnv_a;
      if (valid_a === 1'b1) vks.push_back(k);
    end
    checks++;
    if (rks.size() != 2 || rks[0] != 1 || rks[1] != 187) begin
      errors++;
      $display("FAIL b2b_cnv: got %0d rises first %0d second %0d expected 2 rises at 1 and 187",
               rks.size(), (rks.size() > 0) ? rks[0] : -1, (rks.size() > 1) ? rks[1] : -1);
    end
    checks++;
    if (vks.size() != 2 || vks[0] != 185 || vks[1] != 371) begin
      errors++;
      $display("FAIL b2b_valid: got %0d strobes first %0d second %0d expected 2 at 185 and 371",
               vks.size(), (vks.size() > 0) ? vks[0] : -1, (vks.size() > 1) ? vks[1] : -1);
    end
    checks++;
    if (s1_a !== 18'h26AF3 || s2_a !== 18'h11234) begin
      errors++;
      $display("FAIL b2b_samples: got %h/%h expected 26af3/11234", s1_a, s2_a);
    end
  endtask

  task automatic test_divider();
    int vk, vcnt, rises, cnv_err, sck_err;
    logic prev_sck, exp_sck;
    vk = -1; vcnt = 0; rises = 0; cnv_err = 0; sck_err = 0;
    prev_sck = 1'b0;
    frame_b  = 36'hF_FFFF_FFFF;
    trig_b   = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k == 1) trig_b = 1'b0;
      if (cnv_b !== (k == 1)) cnv_err++;
      exp_sck = (k >= 2 && k <= 73) && (((k - 2) % 2) == 1);
      if (sck_b !== exp_sck) sck_err++;
      if (sck_b === 1'b1 && prev_sck === 1'b0) rises++;
      prev_sck = sck_b;
      if (valid_b === 1'b1) begin
        vcnt++;
        if (vk < 0) vk = k;
      end
    end
    checks++;
    if (cnv_err != 0) begin
      errors++;
      $display("FAIL div_cnv: got %0d bad cycles expected 0", cnv_err);
    end
    checks++;
    if (sck_err != 0 || rises != 36) begin
      errors++;
      $display("FAIL div_sck: got %0d bad cycles %0d rises expected 0 bad 36 rises", sck_err, rises);
    end
    checks++;
    if (vk != 74 || vcnt != 1) begin
      errors++;
      $display("FAIL div_valid: got cycle %0d count %0d expected cycle 74 count 1", vk, vcnt);
    end
    checks++;
    if (s1_b !== 18'h3FFFF || s2_b !== 18'h3FFFF) begin
      errors++;
      $display("FAIL div_samples: got %h/%h expected 3ffff/3ffff", s1_b, s2_b);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_trigger();
    test_single_frame();
    test_alternating();
    test_back_to_back();
    test_divider();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
